// File: rtl/mbox_peer.sv
// Far-end mailbox endpoint: inbound FIFO to a local consumer, registered return stream, responder-side abort.
// Optional protocol-error interrupt is built when MBOX_PEER_ERR_EN is defined.
module mbox_peer #(
    parameter int DEPTH = 16
) (
    input  logic        aclk,
    input  logic        resetn,
    input  logic [31:0] mbox_w_dat,
    input  logic        mbox_w_valid,
    output logic        mbox_w_ready,
    input  logic        mbox_w_done,
    input  logic        mbox_w_abort,
    output logic [31:0] mbox_r_dat,
    output logic        mbox_r_valid,
    input  logic        mbox_r_ready,
    output logic        mbox_r_done,
    output logic        mbox_r_abort,
    output logic [31:0] rx_dat,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic        rx_pkt_ack,
    input  logic [31:0] tx_dat,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic        tx_done,
    input  logic        abort_req,
    output logic        irq_available,
    output logic        irq_abort_init,
    output logic        irq_abort_done,
    output logic        irq_error
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    typedef enum logic [0:0] {RUN, ABORT_WAIT} state_t;

    state_t      state, state_nxt;
    logic        up;
    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, pkt_cnt;
    logic        r_valid_q, done_pend;
    logic [31:0] r_dat_q;
    logic        r_abort_q, abort_init_q, abort_done_q;
    logic        flush, init_evt, done_evt;
    logic        in_run, full, empty, push, pop, tx_hs, pkt_inc, pkt_dec;

    // NOTE: always_comb assigns every output a default first, so no path leaves a latch behind.
    always_comb begin
        state_nxt = state;
        flush     = 1'b0;
        init_evt  = 1'b0;
        done_evt  = 1'b0;
        case (state)
            RUN: begin
                if (mbox_w_abort || abort_req) begin
                    flush = 1'b1;
                    // Simultaneous requests acknowledge each other; no wait state needed.
                    if (mbox_w_abort && abort_req) done_evt = 1'b1;
                    else if (mbox_w_abort)         init_evt = 1'b1;
                    else                           state_nxt = ABORT_WAIT;
                end
            end
            ABORT_WAIT: begin
                if (mbox_w_abort) begin
                    state_nxt = RUN;
                    done_evt  = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state        <= RUN;
            up           <= 1'b0;
            r_abort_q    <= 1'b0;
            abort_init_q <= 1'b0;
            abort_done_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            up           <= 1'b1;
            r_abort_q    <= flush;
            abort_init_q <= init_evt;
            abort_done_q <= done_evt;
        end
    end

    assign in_run  = (state == RUN);
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push    = mbox_w_valid && mbox_w_ready;
    assign pop     = rx_valid && rx_ready;
    assign tx_hs   = tx_valid && tx_ready;
    assign pkt_inc = mbox_w_done && in_run;
    assign pkt_dec = rx_pkt_ack;

    assign mbox_w_ready   = up && !full && in_run;
    assign rx_valid       = !empty;
    assign rx_dat         = rx_valid ? mem[rd_ptr[AW-1:0]] : 32'h0;
    assign tx_ready       = up && in_run && !done_pend && (!r_valid_q || mbox_r_ready);
    assign mbox_r_valid   = r_valid_q;
    assign mbox_r_dat     = r_dat_q;
    assign mbox_r_done    = done_pend && !r_valid_q;
    assign mbox_r_abort   = r_abort_q;
    assign irq_available  = (pkt_cnt != '0);
    assign irq_abort_init = abort_init_q;
    assign irq_abort_done = abort_done_q;

    // NOTE: FIFO storage has no reset; validity is tracked by the pointers alone.
    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= mbox_w_dat;
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pkt_cnt <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pkt_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE;
            if (pop)  rd_ptr <= rd_ptr + ONE;
            if (pkt_inc && !pkt_dec && pkt_cnt != '1)      pkt_cnt <= pkt_cnt + ONE;
            else if (pkt_dec && !pkt_inc && pkt_cnt != '0) pkt_cnt <= pkt_cnt - ONE;
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_valid_q <= 1'b0;
            r_dat_q   <= 32'h0;
            done_pend <= 1'b0;
        end else if (flush) begin
            r_valid_q <= 1'b0;
            r_dat_q   <= 32'h0;
            done_pend <= 1'b0;
        end else begin
            if (tx_hs) begin
                r_valid_q <= 1'b1;
                r_dat_q   <= tx_dat;
            end else if (mbox_r_ready) begin
                r_valid_q <= 1'b0;
            end
            if (in_run && tx_done) done_pend <= 1'b1;
            else if (mbox_r_done)  done_pend <= 1'b0;
        end
    end

`ifdef MBOX_PEER_ERR_EN
    logic have_word, err_q, err_now;

    assign err_now = (in_run && mbox_w_done && !have_word && !push)
                   || (!in_run && (mbox_w_valid || mbox_w_done))
                   || (rx_pkt_ack && pkt_cnt == '0);

    // have_word: at least one word accepted since the last done, abort or reset.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            have_word <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= err_now;
            if (flush || (in_run && mbox_w_done)) have_word <= 1'b0;
            else if (push)                        have_word <= 1'b1;
        end
    end

    assign irq_error = err_q;
`else
    assign irq_error = 1'b0;
`endif

endmodule

// File: tb/tb_mbox_peer.sv
// Self-checking bench for mbox_peer: directed vector table, corner sequences and a randomized run
// compared every cycle against a queue-based reference model.
module tb_mbox_peer;
    localparam int DEPTH   = 16;
    localparam int PKT_MAX = 2*DEPTH - 1;
`ifdef MBOX_PEER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        aclk, resetn;
    logic [31:0] mbox_w_dat, mbox_r_dat, rx_dat, tx_dat;
    logic        mbox_w_valid, mbox_w_ready, mbox_w_done, mbox_w_abort;
    logic        mbox_r_valid, mbox_r_ready, mbox_r_done, mbox_r_abort;
    logic        rx_valid, rx_ready, rx_pkt_ack;
    logic        tx_valid, tx_ready, tx_done, abort_req;
    logic        irq_available, irq_abort_init, irq_abort_done, irq_error;

    mbox_peer #(.DEPTH(DEPTH)) dut (
        .aclk(aclk), .resetn(resetn),
        .mbox_w_dat(mbox_w_dat), .mbox_w_valid(mbox_w_valid), .mbox_w_ready(mbox_w_ready),
        .mbox_w_done(mbox_w_done), .mbox_w_abort(mbox_w_abort),
        .mbox_r_dat(mbox_r_dat), .mbox_r_valid(mbox_r_valid), .mbox_r_ready(mbox_r_ready),
        .mbox_r_done(mbox_r_done), .mbox_r_abort(mbox_r_abort),
        .rx_dat(rx_dat), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_pkt_ack(rx_pkt_ack),
        .tx_dat(tx_dat), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_done(tx_done),
        .abort_req(abort_req),
        .irq_available(irq_available), .irq_abort_init(irq_abort_init),
        .irq_abort_done(irq_abort_done), .irq_error(irq_error)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction-level view of the endpoint.
    logic [31:0] m_q[$];
    int          m_pkt;
    bit          m_up, m_wait, m_rv, m_dp, m_have;
    logic [31:0] m_rd;
    bit          m_p_abort, m_p_init, m_p_done, m_p_err;

    task automatic model_reset();
        m_q.delete();
        m_pkt = 0; m_up = 0; m_wait = 0; m_rv = 0; m_dp = 0; m_have = 0; m_rd = 32'h0;
        m_p_abort = 0; m_p_init = 0; m_p_done = 0; m_p_err = 0;
    endtask

    task automatic compare_model();
        bit ew_ready, etx_ready;
        ew_ready  = m_up && (m_q.size() < DEPTH) && !m_wait;
        etx_ready = m_up && !m_wait && !m_dp && (!m_rv || mbox_r_ready);
        check("w_ready",        mbox_w_ready,   ew_ready);
        check("rx_valid",       rx_valid,       m_q.size() > 0);
        check("rx_dat",         rx_dat,         (m_q.size() > 0) ? m_q[0] : 32'h0);
        check("tx_ready",       tx_ready,       etx_ready);
        check("r_valid",        mbox_r_valid,   m_rv);
        check("r_dat",          mbox_r_dat,     m_rd);
        check("r_done",         mbox_r_done,    m_dp && !m_rv);
        check("r_abort",        mbox_r_abort,   m_p_abort);
        check("irq_available",  irq_available,  m_pkt != 0);
        check("irq_abort_init", irq_abort_init, m_p_init);
        check("irq_abort_done", irq_abort_done, m_p_done);
        check("irq_error",      irq_error,      m_p_err);
    endtask

    task automatic model_step();
        bit ew_ready, etx_ready, push, pop, txhs, rdone, e;
        ew_ready  = m_up && (m_q.size() < DEPTH) && !m_wait;
        etx_ready = m_up && !m_wait && !m_dp && (!m_rv || mbox_r_ready);
        push  = mbox_w_valid && ew_ready;
        pop   = (m_q.size() > 0) && rx_ready;
        txhs  = tx_valid && etx_ready;
        rdone = m_dp && !m_rv;
        e = (!m_wait && mbox_w_done && !m_have && !push)
          || (m_wait && (mbox_w_valid || mbox_w_done))
          || (rx_pkt_ack && m_pkt == 0);
        m_p_err = ERR_EN && e;
        m_p_abort = 0; m_p_init = 0; m_p_done = 0;
        if (!m_wait && (mbox_w_abort || abort_req)) begin
            m_q.delete();
            m_pkt = 0; m_rv = 0; m_rd = 32'h0; m_dp = 0; m_have = 0;
            m_p_abort = 1;
            if (mbox_w_abort && abort_req) m_p_done = 1;
            else if (mbox_w_abort)         m_p_init = 1;
            else                           m_wait = 1;
        end else if (m_wait) begin
            if (mbox_w_abort) begin
                m_wait = 0;
                m_p_done = 1;
            end
            if (rx_pkt_ack && m_pkt > 0) m_pkt--;
        end else begin
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(mbox_w_dat);
            if (mbox_w_done) m_have = 0;
            else if (push)   m_have = 1;
            if (mbox_w_done && !rx_pkt_ack && m_pkt < PKT_MAX) m_pkt++;
            else if (!mbox_w_done && rx_pkt_ack && m_pkt > 0)  m_pkt--;
            if (txhs) begin
                m_rv = 1;
                m_rd = tx_dat;
            end else if (mbox_r_ready) begin
                m_rv = 0;
            end
            if (rdone)   m_dp = 0;
            if (tx_done) m_dp = 1;
        end
        m_up = 1;
    endtask

    task automatic idle_inputs();
        mbox_w_dat = 32'h0; mbox_w_valid = 0; mbox_w_done = 0; mbox_w_abort = 0;
        mbox_r_ready = 0; rx_ready = 0; rx_pkt_ack = 0;
        tx_dat = 32'h0; tx_valid = 0; tx_done = 0; abort_req = 0;
    endtask

    task automatic at_neg();
        @(negedge aclk);
    endtask

    task automatic advance();
        compare_model();
        model_step();
        @(posedge aclk);
        #1;
    endtask

    task automatic tick();
        at_neg();
        advance();
    endtask

    task automatic do_reset(input bit check_outputs);
        idle_inputs();
        resetn = 1'b0;
        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        if (check_outputs) begin
            check("rst_w_ready",  mbox_w_ready, 0);
            check("rst_rx_valid", rx_valid, 0);
            check("rst_rx_dat",   rx_dat, 0);
            check("rst_tx_ready", tx_ready, 0);
            check("rst_r_valid",  mbox_r_valid, 0);
            check("rst_r_dat",    mbox_r_dat, 0);
            check("rst_pulses",   {mbox_r_done, mbox_r_abort, irq_available,
                                   irq_abort_init, irq_abort_done, irq_error}, 0);
        end
        resetn = 1'b1;
    endtask

    typedef struct {
        logic        w_valid;
        logic [31:0] w_dat;
        logic        w_done;
        logic        rx_rdy;
        logic        rx_ack;
        logic        e_w_ready;
        logic        e_rx_valid;
        logic [31:0] e_rx_dat;
        logic        e_avail;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0};
        vecs[1] = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0};
        vecs[2] = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 1'b0};
        vecs[3] = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 1'b0};
        vecs[4] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 1'b1};
        vecs[5] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22, 1'b1};
        vecs[6] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h33, 1'b1};
        vecs[7] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1};
        vecs[8] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0};

        idle_inputs();
        resetn = 1'b0;
        do_reset(1'b1);

        // Reset release and a three-word packet through the inbound path.
        for (int i = 0; i < 9; i++) begin
            mbox_w_valid = vecs[i].w_valid;
            mbox_w_dat   = vecs[i].w_dat;
            mbox_w_done  = vecs[i].w_done;
            rx_ready     = vecs[i].rx_rdy;
            rx_pkt_ack   = vecs[i].rx_ack;
            at_neg();
            check($sformatf("vec%0d_w_ready", i),  mbox_w_ready,  vecs[i].e_w_ready);
            check($sformatf("vec%0d_rx_valid", i), rx_valid,      vecs[i].e_rx_valid);
            if (vecs[i].e_rx_valid)
                check($sformatf("vec%0d_rx_dat", i), rx_dat, vecs[i].e_rx_dat);
            check($sformatf("vec%0d_avail", i),    irq_available, vecs[i].e_avail);
            advance();
        end

        // Fill to DEPTH, then stream push+pop across the pointer wrap.
        do_reset(1'b0);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            mbox_w_valid = 1; mbox_w_dat = 32'hA000 + i;
            tick();
        end
        mbox_w_dat = 32'hA010;
        at_neg();
        check("full_w_ready", mbox_w_ready, 0);
        check("full_head", rx_dat, 32'hA000);
        advance();
        rx_ready = 1;
        at_neg();
        check("full_pop_w_ready", mbox_w_ready, 0);
        advance();
        for (int j = 0; j < 20; j++) begin
            mbox_w_dat = 32'hA010 + j;
            at_neg();
            check("wrap_w_ready", mbox_w_ready, 1);
            check("wrap_order", rx_dat, 32'hA001 + j);
            advance();
        end

        // Outbound: two words, stalled initiator, done with the last word.
        do_reset(1'b0);
        tick();
        tx_valid = 1; tx_dat = 32'hB0;
        at_neg();
        check("out_tx_ready0", tx_ready, 1);
        advance();
        tx_dat = 32'hB1;
        for (int k = 0; k < 5; k++) begin
            at_neg();
            check("out_hold_dat", mbox_r_dat, 32'hB0);
            check("out_hold_valid", mbox_r_valid, 1);
            check("out_hold_tx_ready", tx_ready, 0);
            advance();
        end
        mbox_r_ready = 1; tx_done = 1;
        at_neg();
        check("out_tx_ready1", tx_ready, 1);
        advance();
        tx_valid = 0; tx_done = 0;
        at_neg();
        check("out_dat1", mbox_r_dat, 32'hB1);
        check("out_done_early", mbox_r_done, 0);
        check("out_pend_tx_ready", tx_ready, 0);
        advance();
        mbox_r_ready = 0;
        at_neg();
        check("out_done_pulse", mbox_r_done, 1);
        check("out_done_tx_ready", tx_ready, 0);
        advance();
        at_neg();
        check("out_done_single", mbox_r_done, 0);
        check("out_tx_ready2", tx_ready, 1);
        advance();

        // Initiator abort with four words buffered and one packet pending.
        do_reset(1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            mbox_w_valid = 1; mbox_w_dat = 32'hC0 + i; mbox_w_done = (i == 3);
            tick();
        end
        idle_inputs();
        tick();
        mbox_w_abort = 1;
        at_neg();
        check("iab_pre_avail", irq_available, 1);
        advance();
        mbox_w_abort = 0;
        at_neg();
        check("iab_rx_valid", rx_valid, 0);
        check("iab_avail", irq_available, 0);
        check("iab_r_abort", mbox_r_abort, 1);
        check("iab_init", irq_abort_init, 1);
        check("iab_done", irq_abort_done, 0);
        advance();
        at_neg();
        check("iab_r_abort_once", mbox_r_abort, 0);
        check("iab_init_once", irq_abort_init, 0);
        advance();

        // Local abort, acknowledged three cycles later; inbound words dropped meanwhile.
        abort_req = 1;
        tick();
        abort_req = 0; mbox_w_valid = 1; mbox_w_dat = 32'hD0;
        for (int k = 0; k < 3; k++) begin
            mbox_w_abort = (k == 2);
            at_neg();
            check("lab_w_ready", mbox_w_ready, 0);
            check("lab_tx_ready", tx_ready, 0);
            check("lab_r_abort", mbox_r_abort, k == 0);
            check("lab_done_early", irq_abort_done, 0);
            advance();
        end
        mbox_w_abort = 0; mbox_w_valid = 0;
        at_neg();
        check("lab_done", irq_abort_done, 1);
        check("lab_w_ready_back", mbox_w_ready, 1);
        check("lab_dropped", rx_valid, 0);
        advance();

        // Crossed aborts in the same cycle.
        abort_req = 1; mbox_w_abort = 1;
        tick();
        abort_req = 0; mbox_w_abort = 0;
        at_neg();
        check("xab_r_abort", mbox_r_abort, 1);
        check("xab_done", irq_abort_done, 1);
        check("xab_init", irq_abort_init, 0);
        check("xab_run", mbox_w_ready, 1);
        advance();
        at_neg();
        check("xab_r_abort_once", mbox_r_abort, 0);
        advance();

        // Empty packet: only the second done is a protocol error.
        do_reset(1'b0);
        tick();
        mbox_w_valid = 1; mbox_w_dat = 32'hE0; mbox_w_done = 1;
        tick();
        mbox_w_valid = 0;
        at_neg();
        check("err_first", irq_error, 0);
        advance();
        mbox_w_done = 0;
        at_neg();
        check("err_second", irq_error, ERR_EN);
        advance();
        at_neg();
        check("err_single", irq_error, 0);
        advance();

        // Asynchronous reset mid-packet.
        mbox_w_valid = 1; mbox_w_dat = 32'hF0;
        tick();
        tick();
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_w_ready", mbox_w_ready, 0);
        check("midrst_pulses", {mbox_r_done, mbox_r_abort, irq_abort_init, irq_abort_done}, 0);
        do_reset(1'b0);

        // Randomized traffic against the model.
        tick();
        for (int c = 0; c < 3000; c++) begin
            mbox_w_valid = $urandom_range(0, 1);
            mbox_w_dat   = $urandom;
            mbox_w_done  = ($urandom_range(0, 7) == 0);
            mbox_w_abort = ($urandom_range(0, 63) == 0);
            mbox_r_ready = ($urandom_range(0, 3) != 0);
            rx_ready     = $urandom_range(0, 1);
            rx_pkt_ack   = ($urandom_range(0, 7) == 0);
            tx_valid     = $urandom_range(0, 1);
            tx_dat       = $urandom;
            tx_done      = ($urandom_range(0, 7) == 0);
            abort_req    = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
